decode_writeback: RTL and testbench

- Y86-64 SEQ decode/write-back stage, directly downstream of the fetch stage.
- Consumes icode, rA, rB, and the fetch status flags (halt, invalid_instr, memory_error).
- Holds the 15-entry x 64-bit register file and produces valA/valB for execute.
- Writes valE/valM back on the clock edge and maintains the processor status register (AOK/HLT/ADR/INS), which freezes architectural state on halt or fault.

---
 rtl/decode_writeback_if.sv | 36 +++
 rtl/decode_writeback.sv | 132 +++++++++++++
 tb/tb_decode_writeback.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_writeback_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_writeback_if : fetch/execute-facing bus of the decode/WB stage     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface decode_writeback_if;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        halt;
  logic        invalid_instr;
  logic        memory_error;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [2:0]  stat;
  logic [3:0]  dbg_addr;
  logic [63:0] dbg_data;

  modport master (
    output icode, rA, rB, cnd, valE, valM, halt, invalid_instr, memory_error, dbg_addr,
    input  srcA, srcB, dstE, dstM, valA, valB, stat, dbg_data
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, halt, invalid_instr, memory_error, dbg_addr,
    output srcA, srcB, dstE, dstM, valA, valB, stat, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/decode_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | decode_writeback : Y86-64 SEQ decode, register file, write-back, status  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module decode_writeback #(
  parameter logic [63:0] STACK_INIT = 64'd120,
  parameter int          NREGS      = 15
) (
  input  wire               clk,
  input  wire               rst,
  decode_writeback_if.slave dw_if
);

  localparam logic [3:0] C_RNONE = 4'hF;
  localparam logic [3:0] C_RSP   = 4'h4;

  localparam logic [3:0] C_I_RRMOV = 4'h2;
  localparam logic [3:0] C_I_IRMOV = 4'h3;
  localparam logic [3:0] C_I_RMMOV = 4'h4;
  localparam logic [3:0] C_I_MRMOV = 4'h5;
  localparam logic [3:0] C_I_OPQ   = 4'h6;
  localparam logic [3:0] C_I_CALL  = 4'h8;
  localparam logic [3:0] C_I_RET   = 4'h9;
  localparam logic [3:0] C_I_PUSH  = 4'hA;
  localparam logic [3:0] C_I_POP   = 4'hB;

  typedef enum logic [2:0] {
    S_AOK = 3'd1,
    S_HLT = 3'd2,
    S_ADR = 3'd3,
    S_INS = 3'd4
  } stat_t;

  stat_t       r_stat;
  logic [63:0] r_regs [NREGS];

  logic [3:0]  w_srcA;
  logic [3:0]  w_srcB;
  logic [3:0]  w_dstE;
  logic [3:0]  w_dstM;
  logic        w_we;

  always_comb begin
    w_srcA = C_RNONE;
    w_srcB = C_RNONE;
    w_dstE = C_RNONE;
    w_dstM = C_RNONE;
    case (dw_if.icode)
      C_I_RRMOV: begin
        w_srcA = dw_if.rA;
        w_dstE = dw_if.cnd ? dw_if.rB : C_RNONE;
      end
      C_I_IRMOV: w_dstE = dw_if.rB;
      C_I_RMMOV: begin
        w_srcA = dw_if.rA;
        w_srcB = dw_if.rB;
      end
      C_I_MRMOV: begin
        w_srcB = dw_if.rB;
        w_dstM = dw_if.rA;
      end
      C_I_OPQ: begin
        w_srcA = dw_if.rA;
        w_srcB = dw_if.rB;
        w_dstE = dw_if.rB;
      end
      C_I_CALL: begin
        w_srcB = C_RSP;
        w_dstE = C_RSP;
      end
      C_I_RET: begin
        w_srcA = C_RSP;
        w_srcB = C_RSP;
        w_dstE = C_RSP;
      end
      C_I_PUSH: begin
        w_srcA = dw_if.rA;
        w_srcB = C_RSP;
        w_dstE = C_RSP;
      end
      C_I_POP: begin
        w_srcA = C_RSP;
        w_srcB = C_RSP;
        w_dstE = C_RSP;
        w_dstM = dw_if.rA;
      end
      default: ;
    endcase
  end

  // The halting/faulting instruction's own write is dropped on the same edge.
  assign w_we = (r_stat == S_AOK) && !dw_if.halt && !dw_if.invalid_instr && !dw_if.memory_error;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == int'(C_RSP)) ? STACK_INIT : 64'd0;
      end
    end else if (w_we) begin
      if (w_dstE != C_RNONE) r_regs[w_dstE] <= dw_if.valE;
      // Issued second so valM wins when both ports target the same register.
      if (w_dstM != C_RNONE) r_regs[w_dstM] <= dw_if.valM;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat <= S_AOK;
    end else begin
      case (r_stat)
        S_AOK: begin
          if (dw_if.memory_error)       r_stat <= S_ADR;
          else if (dw_if.invalid_instr) r_stat <= S_INS;
          else if (dw_if.halt)          r_stat <= S_HLT;
        end
        default: r_stat <= r_stat;
      endcase
    end
  end

  assign dw_if.srcA     = w_srcA;
  assign dw_if.srcB     = w_srcB;
  assign dw_if.dstE     = w_dstE;
  assign dw_if.dstM     = w_dstM;
  assign dw_if.valA     = (w_srcA == C_RNONE) ? 64'd0 : r_regs[w_srcA];
  assign dw_if.valB     = (w_srcB == C_RNONE) ? 64'd0 : r_regs[w_srcB];
  assign dw_if.dbg_data = (dw_if.dbg_addr == C_RNONE) ? 64'd0 : r_regs[dw_if.dbg_addr];
  assign dw_if.stat     = r_stat;

endmodule
`default_nettype wire

// File: tb/tb_decode_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_decode_writeback : directed scoreboard bench for decode_writeback     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_decode_writeback;

  logic clk;
  logic rst;

  decode_writeback_if dw ();

  decode_writeback #(
    .STACK_INIT (64'd120),
    .NREGS      (15)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .dw_if (dw.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int checks   = 0;
  int failures = 0;

  task automatic push_exp(input string tag, input logic [63:0] v);
    sb_item_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic check_next(input logic [63:0] obs);
    sb_item_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    dw.icode         = 4'h0;
    dw.rA            = 4'hF;
    dw.rB            = 4'hF;
    dw.cnd           = 1'b0;
    dw.valE          = 64'd0;
    dw.valM          = 64'd0;
    dw.halt          = 1'b0;
    dw.invalid_instr = 1'b0;
    dw.memory_error  = 1'b0;
  endtask

  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic [63:0] ve, input logic [63:0] vm);
    dw.icode = ic;
    dw.rA    = a;
    dw.rB    = b;
    dw.valE  = ve;
    dw.valM  = vm;
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] id, input logic [63:0] v);
    dw.dbg_addr = id;
    push_exp(tag, v);
    #1;
    check_next(dw.dbg_data);
  endtask

  task automatic chk_stat(input string tag, input logic [2:0] v);
    push_exp(tag, {61'd0, v});
    check_next({61'd0, dw.stat});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    nop();
    dw.dbg_addr = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk_stat("reset_stat", 3'd1);
    chk_reg("reset_rsp", 4'd4, 64'd120);
    chk_reg("reset_r0", 4'd0, 64'd0);
    chk_reg("reset_rF", 4'hF, 64'd0);

    // irmovq $5, %rdx
    drive(4'h3, 4'hF, 4'h2, 64'd5, 64'd0);
    #1;
    push_exp("irmov_dstE", 64'd2);   check_next({60'd0, dw.dstE});
    push_exp("irmov_srcA", 64'hF);   check_next({60'd0, dw.srcA});
    push_exp("irmov_srcB", 64'hF);   check_next({60'd0, dw.srcB});
    push_exp("irmov_valA", 64'd0);   check_next(dw.valA);
    push_exp("irmov_valB", 64'd0);   check_next(dw.valB);
    tick();
    nop();
    chk_reg("irmov_r2", 4'd2, 64'd5);

    // Seed r3 = 7, then OPq r2, r3
    drive(4'h3, 4'hF, 4'h3, 64'd7, 64'd0);
    tick();
    nop();
    drive(4'h6, 4'h2, 4'h3, 64'd12, 64'd0);
    #1;
    push_exp("opq_valA", 64'd5);     check_next(dw.valA);
    push_exp("opq_valB", 64'd7);     check_next(dw.valB);
    push_exp("opq_dstE", 64'd3);     check_next({60'd0, dw.dstE});
    tick();
    // Read-before-write: inputs still present, read now reflects the written value
    push_exp("opq_valB_post", 64'd12); check_next(dw.valB);
    nop();
    chk_reg("opq_r3", 4'd3, 64'd12);

    // cmovXX not taken, then taken
    drive(4'h2, 4'h2, 4'h5, 64'd9, 64'd0);
    dw.cnd = 1'b0;
    #1;
    push_exp("cmov_nt_dstE", 64'hF); check_next({60'd0, dw.dstE});
    push_exp("cmov_nt_srcA", 64'd2); check_next({60'd0, dw.srcA});
    tick();
    chk_reg("cmov_nt_r5", 4'd5, 64'd0);
    dw.cnd = 1'b1;
    #1;
    push_exp("cmov_t_dstE", 64'd5);  check_next({60'd0, dw.dstE});
    tick();
    nop();
    chk_reg("cmov_t_r5", 4'd5, 64'd9);

    // mrmovq: M-port only
    drive(4'h5, 4'h7, 4'h3, 64'd1000, 64'd44);
    #1;
    push_exp("mrmov_dstM", 64'd7);   check_next({60'd0, dw.dstM});
    push_exp("mrmov_dstE", 64'hF);   check_next({60'd0, dw.dstE});
    push_exp("mrmov_valB", 64'd12);  check_next(dw.valB);
    tick();
    nop();
    chk_reg("mrmov_r7", 4'd7, 64'd44);

    // pushq decode
    drive(4'hA, 4'h2, 4'hF, 64'd0, 64'd0);
    #1;
    push_exp("push_srcA", 64'd2);    check_next({60'd0, dw.srcA});
    push_exp("push_srcB", 64'd4);    check_next({60'd0, dw.srcB});
    push_exp("push_valB", 64'd120);  check_next(dw.valB);
    nop();

    // popq %rsp: valM wins over valE
    drive(4'hB, 4'h4, 4'hF, 64'd128, 64'd77);
    #1;
    push_exp("pop_dstE", 64'd4);     check_next({60'd0, dw.dstE});
    push_exp("pop_dstM", 64'd4);     check_next({60'd0, dw.dstM});
    push_exp("pop_valA", 64'd120);   check_next(dw.valA);
    tick();
    nop();
    chk_reg("pop_rsp", 4'd4, 64'd77);

    // Invalid instruction suppresses its own write and latches INS
    drive(4'h3, 4'hF, 4'h1, 64'd99, 64'd0);
    dw.invalid_instr = 1'b1;
    tick();
    nop();
    chk_reg("ins_r1", 4'd1, 64'd0);
    chk_stat("ins_stat", 3'd4);
    drive(4'h3, 4'hF, 4'h1, 64'd99, 64'd0);
    tick();
    drive(4'h3, 4'hF, 4'h1, 64'd99, 64'd0);
    dw.memory_error = 1'b1;
    tick();
    nop();
    chk_reg("ins_frozen_r1", 4'd1, 64'd0);
    chk_stat("ins_frozen_stat", 3'd4);

    // Async reset mid-cycle, checked while rst is still high
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_stat("arst_stat", 3'd1);
    chk_reg("arst_rsp", 4'd4, 64'd120);
    chk_reg("arst_r3", 4'd3, 64'd0);
    rst = 1'b0;

    // halt + memory_error -> ADR
    drive(4'h3, 4'hF, 4'h6, 64'd55, 64'd0);
    dw.halt         = 1'b1;
    dw.memory_error = 1'b1;
    tick();
    nop();
    chk_stat("adr_stat", 3'd3);
    chk_reg("adr_r6", 4'd6, 64'd0);

    // halt alone -> HLT
    pulse_reset();
    drive(4'h3, 4'hF, 4'h6, 64'd55, 64'd0);
    dw.halt = 1'b1;
    tick();
    nop();
    chk_stat("hlt_stat", 3'd2);
    chk_reg("hlt_r6", 4'd6, 64'd0);

    // invalid + halt -> INS
    pulse_reset();
    dw.halt          = 1'b1;
    dw.invalid_instr = 1'b1;
    tick();
    nop();
    chk_stat("ins_prio_stat", 3'd4);

    // A clean write after reset proves write-back resumes
    pulse_reset();
    drive(4'h3, 4'hF, 4'h6, 64'hDEAD_BEEF_0123_4567, 64'd0);
    tick();
    nop();
    chk_reg("resume_r6", 4'd6, 64'hDEAD_BEEF_0123_4567);
    chk_stat("resume_stat", 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
